hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS core.
- Consumes the same ID/EXE/MEM register-tracking signals that the EXE forwarding unit reads: destination register, nop flag and write-back flag per stage.
- Produces the hold, flush and bubble controls that create those nop slots: load-use stalls, taken-branch flushes, multi-cycle EXE occupancy and data-memory freezes.
- Sits beside the forwarding unit and drives the write enables and bubble muxes of the PC, IF/ID, ID/EXE and EX/MEM registers.

Parameters:
- MC_LATENCY, 4, total cycles a multi-cycle op (mult/div) occupies EXE; legal range 1..15.
- CNT_W, 4, width of the multi-cycle down-counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  reset; synchronous, active-high.
- rs_id  in  5  rs field of the instruction in ID.
- rt_id  in  5  rt field of the instruction in ID.
- uses_rs_id  in  1  ID instruction reads rs.
- uses_rt_id  in  1  ID instruction reads rt.
- nop_id  in  1  ID slot holds a bubble.
- outReg_exe  in  5  destination register of the EXE instruction.
- memRead_exe  in  1  EXE instruction is a load.
- wb_exe  in  1  EXE instruction writes the register file.
- nop_exe  in  1  EXE slot holds a bubble.
- mc_start_exe  in  1  multi-cycle op entering EXE this cycle.
- branch_taken_exe  in  1  branch resolved taken in EXE.
- mem_busy  in  1  data memory not ready; freeze the pipeline.
- pc_write  out  1  1 = PC updates.
- if_id_write  out  1  1 = IF/ID loads.
- if_id_flush  out  1  1 = IF/ID loads a nop.
- id_exe_bubble  out  1  1 = ID/EXE loads a nop.
- ex_mem_bubble  out  1  1 = EX/MEM loads a nop.
- pipe_freeze  out  1  1 = all pipeline registers, including MEM/WB, hold.
- mc_done  out  1  one-cycle pulse in the last EXE cycle of a multi-cycle op.

Behaviour:
- Registered state:
  - state ∈ {RUN, MC_BUSY}.
  - cnt[CNT_W-1:0].
  - flush_pending.
  - On reset: state=RUN, cnt=0, flush_pending=0.
- All outputs are combinational from the state and inputs.
- While reset is high, outputs are forced to pc_write=0, if_id_write=0, if_id_flush=1, id_exe_bubble=1, ex_mem_bubble=0, pipe_freeze=0, mc_done=0.
- Defaults (RUN, no hazard): pc_write=1, if_id_write=1, all other outputs 0.
- Priority, highest first: mem_busy > branch flush > multi-cycle > load-use.
- mem_busy=1:
  - pipe_freeze=1, pc_write=0, if_id_write=0.
  - Bubble and flush outputs forced to 0.
  - cnt and state hold.
  - If branch_taken_exe=1 in that cycle, flush_pending is set.
- Branch flush:
  - Condition: (branch_taken_exe | flush_pending) & ~mem_busy.
  - Outputs: if_id_flush=1, id_exe_bubble=1, pc_write=1 (the branch target loads).
  - flush_pending clears on the next edge.
  - A load-use hazard in the same cycle is dropped, because the ID instruction is squashed.
- Multi-cycle op:
  - In RUN, mc_start_exe & ~nop_exe loads cnt=MC_LATENCY-1 and moves to MC_BUSY.
  - That cycle and every MC_BUSY cycle with cnt>1: pc_write=0, if_id_write=0, ex_mem_bubble=1.
  - cnt decrements on each non-frozen edge.
  - MC_BUSY with cnt==1: no stall, mc_done=1, next state RUN.
  - Net effect: MC_LATENCY-1 stall cycles, with EX/MEM receiving the result on the final edge.
  - MC_LATENCY=1: no stall, mc_done=1 in the start cycle, state stays RUN.
- Load-use (state RUN, no higher-priority event):
  - Hazard = memRead_exe & wb_exe & ~nop_exe & ~nop_id & outReg_exe≠0 & ((uses_rs_id & rs_id==outReg_exe) | (uses_rt_id & rt_id==outReg_exe)).
  - Response: pc_write=0, if_id_write=0, id_exe_bubble=1 for exactly one cycle.
  - The stall self-terminates: the next cycle sees nop_exe=1, and MEM-stage forwarding supplies the value.
- Register $0 never causes a stall.
- Reset mid-MC_BUSY aborts the op: state=RUN, cnt=0, no mc_done.

Optional Feature:
- HAZARD_STATS_EN defined:
  - Adds output stall_cycles[31:0], a saturating count of cycles with pc_write=0 & ~reset.
  - Adds output flush_count[15:0], a saturating count of branch flushes applied.
  - Both clear on reset.
- Not defined: neither port exists and no counter logic is built.

Decomposition:
- Shared package (hazard_pkg):
  - State encoding RUN=1'b0, MC_BUSY=1'b1.
  - REG_ZERO=5'd0.
  - Default MC_LATENCY constant.
- One natural sub-module, load_use_detect: purely combinational hazard compare, reusable by a future ID-stage branch forwarding check.

Test Plan:
- Load-use: lw $5 in EXE (memRead_exe=1, wb_exe=1, outReg_exe=5), ID rs_id=5, uses_rs_id=1 -> one cycle of pc_write=0, if_id_write=0, id_exe_bubble=1; the next cycle with nop_exe=1 gives defaults.
- Zero/unused register: outReg_exe=0 matching rs_id=0, or rt_id=5 with uses_rt_id=0 -> no stall.
- Multi-cycle, MC_LATENCY=4: mc_start_exe pulse -> 3 cycles of pc_write=0 and ex_mem_bubble=1; mc_done=1 in the 4th cycle; then RUN.
- Freeze during multi-cycle: mem_busy=1 for 2 cycles mid-op -> pipe_freeze=1 and cnt holds; mc_done arrives 2 cycles later than without the freeze.
- Branch during freeze: branch_taken_exe=1 with mem_busy=1, then mem_busy=0 -> the flush is deferred, and if_id_flush=1, id_exe_bubble=1 occur in the first unfrozen cycle.
- Reset mid-op: assert reset at cnt=2 -> outputs take their reset values; after release, state RUN and no mc_done.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard / stall controller.
//   - state_e    : controller state encoding (RUN, MC_BUSY)
//   - REG_ZERO   : the hard-wired zero register, which never creates a dependency
//   - MC_LATENCY_DEFAULT : default number of EXE cycles of a multi-cycle op
//   - reg_dep()  : "this source operand reads that destination" compare
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_e;

    localparam logic [4:0]  REG_ZERO           = 5'd0;
    localparam int unsigned MC_LATENCY_DEFAULT = 4;

    // True when an operand that is actually read matches a real (non-$0) destination.
    function automatic logic reg_dep(input logic [4:0] src, input logic uses,
                                     input logic [4:0] dst);
        return uses && (dst != REG_ZERO) && (src == dst);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard compare.
// Flags an ID instruction that reads the destination of a load currently in EXE.
// Kept separate so an ID-stage branch operand check can reuse it.
//   rs_i, rt_i, uses_rs_i, uses_rt_i : ID-stage source operands and read flags
//   nop_id_i                         : ID slot is a bubble
//   dst_i                            : destination register of the producer in EXE
//   mem_read_i, wb_i, nop_exe_i      : producer is a load, writes back, is a bubble
//   hazard_o                         : 1 = ID must wait one cycle for the load data
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    input  logic       uses_rs_i,
    input  logic       uses_rt_i,
    input  logic       nop_id_i,
    input  logic [4:0] dst_i,
    input  logic       mem_read_i,
    input  logic       wb_i,
    input  logic       nop_exe_i,
    output logic       hazard_o
);

    logic producer_valid;
    logic consumer_valid;

    always_comb begin
        producer_valid = mem_read_i & wb_i & ~nop_exe_i;
        consumer_valid = ~nop_id_i;
        hazard_o       = producer_valid & consumer_valid &
                         (reg_dep(rs_i, uses_rs_i, dst_i) | reg_dep(rt_i, uses_rt_i, dst_i));
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: hold / flush / bubble controller for the 5-stage MIPS pipeline.
// Event priority, highest first: memory freeze, branch flush, multi-cycle EXE op, load-use.
// Inputs:
//   clk, reset (synchronous, active-high)
//   rs_id, rt_id, uses_rs_id, uses_rt_id, nop_id : ID-stage operands
//   outReg_exe, memRead_exe, wb_exe, nop_exe     : EXE-stage producer
//   mc_start_exe      : multi-cycle op (mult/div) entering EXE
//   branch_taken_exe  : branch resolved taken in EXE
//   mem_busy          : data memory stall, freezes the whole pipeline
// Outputs:
//   pc_write, if_id_write, if_id_flush, id_exe_bubble, ex_mem_bubble, pipe_freeze, mc_done
// Optional (macro HAZARD_STATS_EN): stall_cycles[31:0], flush_count[15:0] saturating counters.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MC_LATENCY = MC_LATENCY_DEFAULT,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic       uses_rs_id,
    input  logic       uses_rt_id,
    input  logic       nop_id,
    input  logic [4:0] outReg_exe,
    input  logic       memRead_exe,
    input  logic       wb_exe,
    input  logic       nop_exe,
    input  logic       mc_start_exe,
    input  logic       branch_taken_exe,
    input  logic       mem_busy,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_exe_bubble,
    output logic       ex_mem_bubble,
    output logic       pipe_freeze,
    output logic       mc_done
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flush_pending_q, flush_pending_d;

    logic             lu_hazard;
    logic             mc_start;
    logic             mc_stall;
    logic             mc_last;
    logic             flush_now;
    state_e           mc_state_nxt;
    logic [CNT_W-1:0] mc_cnt_nxt;

    load_use_detect u_load_use_detect (
        .rs_i       (rs_id),
        .rt_i       (rt_id),
        .uses_rs_i  (uses_rs_id),
        .uses_rt_i  (uses_rt_id),
        .nop_id_i   (nop_id),
        .dst_i      (outReg_exe),
        .mem_read_i (memRead_exe),
        .wb_i       (wb_exe),
        .nop_exe_i  (nop_exe),
        .hazard_o   (lu_hazard)
    );

    // Multi-cycle sequencing. Computed as if the cycle were unfrozen; a freeze simply
    // refuses to commit it. The sequencing is independent of branch flushes, which only
    // act on the IF/ID and ID/EXE registers.
    always_comb begin
        mc_start     = (state_q == RUN) & mc_start_exe & ~nop_exe;
        mc_stall     = 1'b0;
        mc_last      = 1'b0;
        mc_state_nxt = state_q;
        mc_cnt_nxt   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (mc_start) begin
                    if (MC_LATENCY > 1) begin
                        mc_stall     = 1'b1;
                        mc_state_nxt = MC_BUSY;
                        mc_cnt_nxt   = CNT_INIT;
                    end else begin
                        // Single-cycle latency: completes in the start cycle.
                        mc_last = 1'b1;
                    end
                end
            end
            MC_BUSY: begin
                if (cnt_q > CNT_ONE) begin
                    mc_stall   = 1'b1;
                    mc_cnt_nxt = cnt_q - CNT_ONE;
                end else begin
                    mc_last      = 1'b1;
                    mc_state_nxt = RUN;
                    mc_cnt_nxt   = '0;
                end
            end
            default: begin
                mc_state_nxt = RUN;
                mc_cnt_nxt   = '0;
            end
        endcase
    end

    // Next state: a freeze holds everything but remembers a taken branch, so the
    // squash happens in the first unfrozen cycle.
    always_comb begin
        flush_now = (branch_taken_exe | flush_pending_q) & ~mem_busy;
        if (mem_busy) begin
            state_d         = state_q;
            cnt_d           = cnt_q;
            flush_pending_d = flush_pending_q | branch_taken_exe;
        end else begin
            state_d         = mc_state_nxt;
            cnt_d           = mc_cnt_nxt;
            flush_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= RUN;
            cnt_q           <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_exe_bubble = 1'b0;
        ex_mem_bubble = 1'b0;
        pipe_freeze   = 1'b0;
        mc_done       = 1'b0;
        if (reset) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            if_id_flush   = 1'b1;
            id_exe_bubble = 1'b1;
        end else if (mem_busy) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (flush_now) begin
            // PC loads the branch target; younger instructions are squashed.
            if_id_flush   = 1'b1;
            id_exe_bubble = 1'b1;
            mc_done       = mc_last;
        end else if (mc_stall) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            ex_mem_bubble = 1'b1;
        end else begin
            mc_done = mc_last;
            // A load cannot occupy EXE while a multi-cycle op does.
            if ((state_q == RUN) && !mc_start && lu_hazard) begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_exe_bubble = 1'b1;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!pc_write && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (flush_now && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule
